// File: rtl/sap_1_ram_16x8_pkg.sv
// Shared types, SAP-1 opcodes and the demo program image for the 16x8 RAM.
// The image is only used when SAP_1_RAM_PRELOAD_EN is defined.
package sap_1_ram_16x8_pkg;

   localparam int unsigned RAM_DEPTH = 16;
   localparam int unsigned ADDR_W    = 4;
   localparam int unsigned DATA_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_ACK   = 2'd2
   } prog_state_e;

   localparam logic [3:0] OP_LDA = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_OUT = 4'hE;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Demo program: LDA 9, ADD A, ADD B, SUB C, OUT, HLT -> 10+14+18-20 = 1C.
   function automatic logic [DATA_W-1:0] preload_word(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] w;
      w = 8'h00;
      case (a)
         4'h0:    w = {OP_LDA, 4'h9};
         4'h1:    w = {OP_ADD, 4'hA};
         4'h2:    w = {OP_ADD, 4'hB};
         4'h3:    w = {OP_SUB, 4'hC};
         4'h4:    w = {OP_OUT, 4'h0};
         4'h5:    w = {OP_HLT, 4'h0};
         4'h9:    w = 8'h10;
         4'hA:    w = 8'h14;
         4'hB:    w = 8'h18;
         4'hC:    w = 8'h20;
         default: w = 8'h00;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sap_1_ram_prog_fsm.sv
// Programming-port write FSM for the SAP-1 RAM: IDLE -> WRITE -> ACK.
// Holds the captured request and the auto-increment pointer; drives a write strobe.
module sap_1_ram_prog_fsm
   import sap_1_ram_16x8_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Prog,
   input  logic              prog_valid,
   input  logic              prog_auto,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_ready,
   output logic              prog_done,
   output logic [ADDR_W-1:0] prog_ptr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data
);

   prog_state_e       state, state_nxt;
   logic              accept;
   logic              auto_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;

   // NOTE: every output is given a default before the case so no path leaves
   // a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      prog_ready = 1'b0;
      prog_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            prog_ready = Prog;
            if (prog_valid && Prog) state_nxt = ST_WRITE;
         end
         ST_WRITE: state_nxt = ST_ACK;
         ST_ACK: begin
            prog_done = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept  = prog_valid & prog_ready;
   // A reset landing on the WRITE cycle discards the pending word.
   assign wr_en   = (state == ST_WRITE) & ~Rst;
   assign wr_addr = addr_q;
   assign wr_data = data_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= ST_IDLE;
         prog_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (wr_en && auto_q) prog_ptr <= prog_ptr + ADDR_W'(1);
      end
   end

   // Request capture needs no reset: it is only consumed after an accept.
   always_ff @(posedge Clk) begin
      if (accept) begin
         addr_q <= prog_auto ? prog_ptr : prog_addr;
         data_q <= prog_data;
         auto_q <= prog_auto;
      end
   end

endmodule

// File: rtl/sap_1_ram_16x8.sv
// SAP-1 16x8 program/data RAM: combinational W-bus read plus a valid/ready
// programming port. Define SAP_1_RAM_PRELOAD_EN to load the demo image on Rst.
module sap_1_ram_16x8
   import sap_1_ram_16x8_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] address,
   input  logic              CEbar,
   input  logic              Prog,
   input  logic              prog_valid,
   input  logic              prog_auto,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [DATA_W-1:0] prog_data,
   output logic              prog_ready,
   output logic              prog_done,
   output logic [ADDR_W-1:0] prog_ptr,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_en
);

   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] mem [RAM_DEPTH];

   sap_1_ram_prog_fsm u_prog_fsm (
      .Clk        (Clk),
      .Rst        (Rst),
      .Prog       (Prog),
      .prog_valid (prog_valid),
      .prog_auto  (prog_auto),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .prog_ready (prog_ready),
      .prog_done  (prog_done),
      .prog_ptr   (prog_ptr),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data)
   );

   // NOTE: the array is reset only when the demo image is wanted; otherwise
   // leaving it unreset lets it map onto plain RAM and keeps contents across Rst.
   always_ff @(posedge Clk) begin
`ifdef SAP_1_RAM_PRELOAD_EN
      if (Rst) begin
         for (int i = 0; i < RAM_DEPTH; i++) mem[i] <= preload_word(ADDR_W'(i));
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
`else
      if (wr_en) mem[wr_addr] <= wr_data;
`endif
   end

   // Read is independent of the write FSM; a same-cycle write shows next cycle.
   assign bus_en  = ~CEbar & ~Prog;
   assign bus_out = bus_en ? mem[address] : '0;

endmodule

// File: tb/tb_sap_1_ram_16x8.sv
// Scoreboard bench for sap_1_ram_16x8: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_sap_1_ram_16x8;

   logic       Clk = 1'b0, Rst = 1'b1, CEbar = 1'b1, Prog = 1'b0;
   logic       prog_valid = 1'b0, prog_auto = 1'b0;
   logic [3:0] address = '0, prog_addr = '0;
   logic [7:0] prog_data = '0;
   logic       prog_ready, prog_done, bus_en;
   logic [3:0] prog_ptr;
   logic [7:0] bus_out;

   sap_1_ram_16x8 dut (
      .Clk(Clk), .Rst(Rst), .address(address), .CEbar(CEbar), .Prog(Prog),
      .prog_valid(prog_valid), .prog_auto(prog_auto), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_ready(prog_ready), .prog_done(prog_done),
      .prog_ptr(prog_ptr), .bus_out(bus_out), .bus_en(bus_en)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef enum int {K_DONE, K_BUS, K_EN, K_READY, K_PTR} kind_e;
   typedef struct {
      int         cyc;
      kind_e      kind;
      logic [8:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0, n_bad = 0;
   bit   mon_en = 0;

   // Reference model: word array, known flags, pointer.
   logic [7:0] mem_m [16];
   bit         known [16];
   int         ptr_m;
   logic [7:0] image [16] = '{8'h09, 8'h1A, 8'h1B, 8'h2C, 8'hE0, 8'hF0, 8'h00, 8'h00,
                              8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00};

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   task automatic push(input int c, input kind_e k, input logic [8:0] v);
      exp_t e;
      e.cyc = c; e.kind = k; e.val = v;
      exp_q.push_back(e);
   endtask

   always @(negedge Clk) begin : monitor
      bit   exp_done;
      exp_t e;
      if (mon_en) begin
         exp_done = 0;
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            e = exp_q[i];
            if (e.cyc < cyc) begin
               n_cmp++; n_bad++;
               $display("FAIL stale_%s cyc=%0d actual=none required=%h", e.kind.name(), e.cyc, e.val);
               exp_q.delete(i);
            end else if (e.cyc == cyc) begin
               case (e.kind)
                  K_DONE: begin
                     exp_done = 1;
                     check("done_ptr", {5'b0, prog_ptr}, e.val);
                  end
                  K_BUS:   check("bus", {bus_en, bus_out}, e.val);
                  K_EN:    check("bus_en", {8'b0, bus_en}, e.val);
                  K_READY: check("ready", {8'b0, prog_ready}, e.val);
                  K_PTR:   check("ptr", {5'b0, prog_ptr}, e.val);
                  default: ;
               endcase
               exp_q.delete(i);
            end
         end
         check("done", {8'b0, prog_done}, {8'b0, exp_done});
      end
   end

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic model_reset();
      ptr_m = 0;
`ifdef SAP_1_RAM_PRELOAD_EN
      for (int i = 0; i < 16; i++) begin
         mem_m[i] = image[i];
         known[i] = 1;
      end
`endif
   endtask

   task automatic do_read(input logic [3:0] a, input logic ce, input logic pg);
      step();
      prog_valid = 0; Prog = pg; CEbar = ce; address = a;
      if (ce || pg)    push(cyc, K_BUS, 9'h000);
      else if (known[a]) push(cyc, K_BUS, {1'b1, mem_m[a]});
      else             push(cyc, K_EN, 9'h001);
      push(cyc, K_READY, {8'b0, pg});
   endtask

   task automatic do_write(input logic au, input logic [3:0] a, input logic [7:0] d);
      logic [3:0] tgt;
      step();
      Prog = 1; prog_valid = 1; prog_auto = au; prog_addr = a; prog_data = d;
      CEbar = 0; address = 4'($urandom);
      push(cyc, K_READY, 9'h001); push(cyc, K_BUS, 9'h000);
      tgt = au ? 4'(ptr_m) : a;
      mem_m[tgt] = d; known[tgt] = 1;
      if (au) ptr_m = (ptr_m + 1) % 16;
      push(cyc + 2, K_DONE, 9'(ptr_m));
      for (int s = 0; s < 2; s++) begin
         step();
         // Junk on the port while busy must be ignored.
         prog_valid = 1'($urandom); prog_auto = 1'($urandom);
         prog_addr = 4'($urandom); prog_data = 8'($urandom);
         push(cyc, K_READY, 9'h000); push(cyc, K_BUS, 9'h000);
      end
   endtask

   task automatic mode_drop(input logic [3:0] a);
      logic [7:0] old, d;
      bit         oldk;
      old = mem_m[a]; oldk = known[a];
      d = oldk ? ~old : 8'($urandom);
      step();
      Prog = 1; prog_valid = 1; prog_auto = 0; prog_addr = a; prog_data = d;
      CEbar = 0; address = a;
      push(cyc, K_READY, 9'h001); push(cyc, K_BUS, 9'h000);
      mem_m[a] = d; known[a] = 1;
      push(cyc + 2, K_DONE, 9'(ptr_m));
      step();
      Prog = 0; prog_valid = 1; prog_addr = a ^ 4'h1; prog_data = ~d;
      push(cyc, K_READY, 9'h000);
      if (oldk) push(cyc, K_BUS, {1'b1, old});
      else      push(cyc, K_EN, 9'h001);
      repeat (2) begin
         step();
         push(cyc, K_READY, 9'h000); push(cyc, K_BUS, {1'b1, d});
      end
   endtask

   task automatic reset_mid();
      step();
      Prog = 1; prog_valid = 1; prog_auto = 1; prog_data = ~mem_m[ptr_m];
      push(cyc, K_READY, 9'h001);
      step();
      Rst = 1; prog_valid = 0;
      push(cyc, K_READY, 9'h000); push(cyc, K_PTR, 9'(ptr_m));
      step();
      Rst = 0;
      model_reset();
      push(cyc, K_PTR, 9'h000); push(cyc, K_READY, 9'h001);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) known[i] = 0;
      Rst = 1;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 0;
      model_reset();
      mon_en = 1;
      push(cyc, K_PTR, 9'h000); push(cyc, K_READY, 9'h000); push(cyc, K_BUS, 9'h000);

`ifdef SAP_1_RAM_PRELOAD_EN
      do_read(4'h3, 0, 0);
      do_read(4'h3, 1, 0);
      for (int i = 0; i < 16; i++) do_read(4'(i), 0, 0);
`endif
      repeat (4) do_read(4'($urandom), 0, 1);

      do_write(0, 4'h7, 8'hA5);
      do_read(4'h7, 0, 0);
      do_read(4'h7, 1, 0);
      repeat (6) do_write(0, 4'($urandom), 8'($urandom));

      for (int i = 0; i < 17; i++) do_write(1, 4'($urandom), 8'(i));
      for (int i = 0; i < 16; i++) do_read(4'(i), 0, 0);

      mode_drop(4'h5);
      do_read(4'h5, 0, 0);
      do_read(4'h4, 0, 0);

      repeat (40) begin
         case ($urandom_range(0, 3))
            0:       do_write(0, 4'($urandom), 8'($urandom));
            1:       do_write(1, 4'($urandom), 8'($urandom));
            2:       do_read(4'($urandom), 1'($urandom), 1'($urandom));
            default: do_read(4'($urandom), 0, 0);
         endcase
      end

      do_write(1, 4'h0, 8'h3C);
      do_write(1, 4'h0, 8'hC3);
      reset_mid();
      for (int i = 0; i < 16; i++) do_read(4'(i), 0, 0);

      repeat (4) step();
      @(negedge Clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain actual=%0d_pending required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
